// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_ctrl_if : frame load / display drive bundle for seg_scan_ctrl   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface seg_scan_ctrl_if;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_in;
  logic [3:0]  dp_in;
  logic [3:0]  b_out;
  logic [3:0]  an;
  logic        dp;
  logic        pending;
  logic        load_ack;
  logic        frame_tick;

  modport master (
    output load, digits_in, blank_in, dp_in,
    input  b_out, an, dp, pending, load_ack, frame_tick
  );

  modport slave (
    input  load, digits_in, blank_in, dp_in,
    output b_out, an, dp, pending, load_ack, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_ctrl : 4-digit multiplexed 7-seg scanner, double-buffered frame |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 1000
) (
  input  wire logic       clk,
  input  wire logic       reset,
  seg_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] C_DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] C_SLOT_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [0:0] {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      sh_digits_q, sh_digits_d, ac_digits_q, ac_digits_d;
  logic [3:0]       sh_blank_q, sh_blank_d, ac_blank_q, ac_blank_d;
  logic [3:0]       sh_dp_q, sh_dp_d, ac_dp_q, ac_dp_d;
  logic             pending_q, pending_d;
  logic             load_ack_q, load_ack_d;
  logic             frame_tick_q, frame_tick_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       b_out_q, b_out_d;
  logic             dp_q, dp_d;
  logic             boundary;
  logic             lit;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    sh_digits_d  = sh_digits_q;
    sh_blank_d   = sh_blank_q;
    sh_dp_d      = sh_dp_q;
    ac_digits_d  = ac_digits_q;
    ac_blank_d   = ac_blank_q;
    ac_dp_d      = ac_dp_q;
    pending_d    = pending_q;
    load_ack_d   = 1'b0;
    frame_tick_d = 1'b0;
    boundary     = 1'b0;
    lit          = 1'b0;
    an_d         = 4'b1111;
    dp_d         = 1'b1;
    b_out_d      = 4'd0;

    case (state_q)
      ST_DEAD: begin
        if (cnt_q == C_DEAD_LAST) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (cnt_q == C_SLOT_LAST) begin
          state_d  = ST_DEAD;
          cnt_d    = '0;
          idx_d    = idx_q + 2'd1;
          boundary = (idx_q == 2'd3);
        end
      end
      default: state_d = ST_DEAD;
    endcase

    // Active set takes the pre-edge shadow, so a coincident load lands in the
    // shadow afterwards and stays pending for the next frame.
    if (boundary) begin
      frame_tick_d = 1'b1;
      if (pending_q) begin
        ac_digits_d = sh_digits_q;
        ac_blank_d  = sh_blank_q;
        ac_dp_d     = sh_dp_q;
        pending_d   = 1'b0;
        load_ack_d  = 1'b1;
      end
    end

    if (bus.load) begin
      sh_digits_d = bus.digits_in;
      sh_blank_d  = bus.blank_in;
      sh_dp_d     = bus.dp_in;
      pending_d   = 1'b1;
    end

    b_out_d = ac_digits_d[idx_d*4 +: 4];
    lit     = (state_d == ST_SHOW) && !ac_blank_d[idx_d];
    if (lit) begin
      an_d = ~(4'b0001 << idx_d);
      dp_d = ~ac_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_DEAD;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      sh_digits_q  <= 16'd0;
      sh_blank_q   <= 4'b1111;
      sh_dp_q      <= 4'd0;
      ac_digits_q  <= 16'd0;
      ac_blank_q   <= 4'b1111;
      ac_dp_q      <= 4'd0;
      pending_q    <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= 4'b1111;
      b_out_q      <= 4'd0;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_digits_q  <= sh_digits_d;
      sh_blank_q   <= sh_blank_d;
      sh_dp_q      <= sh_dp_d;
      ac_digits_q  <= ac_digits_d;
      ac_blank_q   <= ac_blank_d;
      ac_dp_q      <= ac_dp_d;
      pending_q    <= pending_d;
      load_ack_q   <= load_ack_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      b_out_q      <= b_out_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.b_out      = b_out_q;
  assign bus.an         = an_q;
  assign bus.dp         = dp_q;
  assign bus.pending    = pending_q;
  assign bus.load_ack   = load_ack_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg_scan_ctrl : directed bench, REFRESH_DIV=4 / DEAD_CYC=1 (16-cycle  |
// | frames). Rev 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_seg_scan_ctrl;
  localparam int RD = 4;
  localparam int DC = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.REFRESH_DIV(RD), .DEAD_CYC(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int ph = 0;   // edges since reset, modulo one frame

  task automatic step;
    @(posedge clk);
    #1;
    ph = (ph + 1) % 16;
  endtask

  // Expected {an, dp, b_out} at frame position p for a given applied frame.
  function automatic logic [8:0] model(input logic [15:0] d, input logic [3:0] bl,
                                       input logic [3:0] dm, input int p);
    int ix;
    logic lit;
    logic [3:0] a;
    logic o;
    ix  = p / 4;
    lit = ((p % 4) != 0) && (bl[ix] == 1'b0);
    a   = lit ? ~(4'b0001 << ix) : 4'b1111;
    o   = lit ? ~dm[ix] : 1'b1;
    return {a, o, d[ix*4 +: 4]};
  endfunction

  task automatic drive(input logic ld, input logic [15:0] d, input logic [3:0] bl, input logic [3:0] dm);
    bus.load = ld;
    bus.digits_in = d;
    bus.blank_in = bl;
    bus.dp_in = dm;
  endtask

  task automatic test_reset;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    reset = 1'b1;
    step;
    step;
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected 1111", bus.an); end
    checks++; if (bus.b_out !== 4'd0) begin errors++; $display("FAIL reset_b_out: got %h expected 0", bus.b_out); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", bus.dp); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", bus.pending); end
    checks++; if (bus.load_ack !== 1'b0) begin errors++; $display("FAIL reset_load_ack: got %b expected 0", bus.load_ack); end
    checks++; if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b expected 0", bus.frame_tick); end
    reset = 1'b0;
    ph = 0;
    for (int i = 1; i <= 64; i++) begin
      step;
      checks++;
      if ({bus.an, bus.b_out, bus.frame_tick} !== {4'b1111, 4'd0, (i % 16) == 0}) begin
        errors++;
        $display("FAIL reset_dark edge %0d: an/b_out/tick got %b %h %b expected 1111 0 %b",
                 i, bus.an, bus.b_out, bus.frame_tick, (i % 16) == 0);
      end
    end
  endtask

  task automatic test_basic_scan;
    logic [8:0] e;
    drive(1'b1, 16'h1234, 4'b0000, 4'b0010);
    step;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    checks++; if ({bus.pending, bus.load_ack} !== 2'b10) begin errors++; $display("FAIL basic_pending: got %b expected 10", {bus.pending, bus.load_ack}); end
    for (int i = 0; i < 15; i++) begin
      step;
      checks++;
      if ({bus.load_ack, bus.pending} !== {ph == 0, ph != 0}) begin
        errors++;
        $display("FAIL basic_ack ph %0d: ack/pending got %b expected %b", ph, {bus.load_ack, bus.pending}, {ph == 0, ph != 0});
      end
    end
    for (int p = 0; p < 16; p++) begin
      if (p != 0) step;
      e = model(16'h1234, 4'b0000, 4'b0010, p);
      checks++;
      if ({bus.an, bus.dp, bus.b_out, bus.frame_tick, bus.load_ack} !== {e, p == 0, p == 0}) begin
        errors++;
        $display("FAIL basic_scan p %0d: an/dp/b/tick/ack got %b expected %b", p,
                 {bus.an, bus.dp, bus.b_out, bus.frame_tick, bus.load_ack}, {e, p == 0, p == 0});
      end
    end
    step;
    checks++; if ({bus.frame_tick, bus.load_ack} !== 2'b10) begin errors++; $display("FAIL basic_idle_boundary: tick/ack got %b expected 10", {bus.frame_tick, bus.load_ack}); end
  endtask

  task automatic test_overwrite;
    logic [8:0] e;
    int acks;
    acks = 0;
    drive(1'b1, 16'h1111, 4'b0000, 4'b0000);
    step;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (4) step;
    drive(1'b1, 16'h2222, 4'b0000, 4'b0000);
    step;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      step;
      if (bus.load_ack === 1'b1) acks++;
    end
    checks++; if (acks !== 1) begin errors++; $display("FAIL overwrite_ack_count: got %0d expected 1", acks); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL overwrite_pending: got %b expected 0", bus.pending); end
    for (int p = 0; p < 16; p++) begin
      if (p != 0) step;
      e = model(16'h2222, 4'b0000, 4'b0000, p);
      checks++;
      if ({bus.an, bus.dp, bus.b_out, bus.frame_tick, bus.load_ack} !== {e, p == 0, p == 0}) begin
        errors++;
        $display("FAIL overwrite_scan p %0d: an/dp/b/tick/ack got %b expected %b", p,
                 {bus.an, bus.dp, bus.b_out, bus.frame_tick, bus.load_ack}, {e, p == 0, p == 0});
      end
    end
    step;
    checks++; if (bus.load_ack !== 1'b0) begin errors++; $display("FAIL overwrite_second_ack: got %b expected 0", bus.load_ack); end
  endtask

  task automatic test_load_boundary;
    logic [8:0] e;
    drive(1'b1, 16'h1234, 4'b0000, 4'b0000);
    step;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (14) step;
    drive(1'b1, 16'h5678, 4'b0000, 4'b1001);
    step;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    checks++;
    if ({bus.load_ack, bus.pending, bus.frame_tick} !== 3'b111) begin
      errors++;
      $display("FAIL boundary_load: ack/pending/tick got %b expected 111", {bus.load_ack, bus.pending, bus.frame_tick});
    end
    for (int p = 0; p < 16; p++) begin
      if (p != 0) step;
      e = model(16'h1234, 4'b0000, 4'b0000, p);
      checks++;
      if ({bus.an, bus.dp, bus.b_out, bus.frame_tick, bus.load_ack} !== {e, p == 0, p == 0}) begin
        errors++;
        $display("FAIL boundary_first p %0d: an/dp/b/tick/ack got %b expected %b", p,
                 {bus.an, bus.dp, bus.b_out, bus.frame_tick, bus.load_ack}, {e, p == 0, p == 0});
      end
    end
    step;
    checks++; if ({bus.load_ack, bus.pending} !== 2'b10) begin errors++; $display("FAIL boundary_second_ack: ack/pending got %b expected 10", {bus.load_ack, bus.pending}); end
    for (int p = 0; p < 16; p++) begin
      if (p != 0) step;
      e = model(16'h5678, 4'b0000, 4'b1001, p);
      checks++;
      if ({bus.an, bus.dp, bus.b_out, bus.frame_tick, bus.load_ack} !== {e, p == 0, p == 0}) begin
        errors++;
        $display("FAIL boundary_second p %0d: an/dp/b/tick/ack got %b expected %b", p,
                 {bus.an, bus.dp, bus.b_out, bus.frame_tick, bus.load_ack}, {e, p == 0, p == 0});
      end
    end
    step;
  endtask

  task automatic test_blank;
    logic [8:0] e;
    drive(1'b1, 16'h5E39, 4'b1010, 4'b1111);
    step;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (15) step;
    for (int p = 0; p < 16; p++) begin
      if (p != 0) step;
      e = model(16'h5E39, 4'b1010, 4'b1111, p);
      checks++;
      if ({bus.an, bus.dp, bus.b_out, bus.frame_tick, bus.load_ack} !== {e, p == 0, p == 0}) begin
        errors++;
        $display("FAIL blank_scan p %0d: an/dp/b/tick/ack got %b expected %b", p,
                 {bus.an, bus.dp, bus.b_out, bus.frame_tick, bus.load_ack}, {e, p == 0, p == 0});
      end
      checks++;
      if (bus.an === 4'b1101 || bus.an === 4'b0111) begin
        errors++;
        $display("FAIL blank_anode p %0d: got %b expected neither 1101 nor 0111", p, bus.an);
      end
    end
    step;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 16'h4321, 4'b0000, 4'b0000);
    step;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (8) step;
    checks++;
    if ({bus.an, bus.b_out, bus.pending} !== {4'b1011, 4'hE, 1'b1}) begin
      errors++;
      $display("FAIL midscan_pre: an/b/pending got %b %h %b expected 1011 e 1", bus.an, bus.b_out, bus.pending);
    end
    reset = 1'b1;
    step;
    reset = 1'b0;
    ph = 0;
    checks++;
    if ({bus.an, bus.pending, bus.b_out, bus.dp} !== {4'b1111, 1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL midscan_reset: an/pending/b/dp got %b %b %h %b expected 1111 0 0 1",
               bus.an, bus.pending, bus.b_out, bus.dp);
    end
    for (int i = 1; i <= 16; i++) begin
      step;
      checks++;
      if ({bus.load_ack, bus.frame_tick, bus.an} !== {1'b0, i == 16, 4'b1111}) begin
        errors++;
        $display("FAIL midscan_after edge %0d: ack/tick/an got %b expected %b", i,
                 {bus.load_ack, bus.frame_tick, bus.an}, {1'b0, i == 16, 4'b1111});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_overwrite();
    test_load_boundary();
    test_blank();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
